rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameters: AW, 4, ROM address width (address ports are AW+1 bits); DW, 8, ROM word width; EXTRA, 4, width of extra-word count; LO0, 0, requester-0 lower bound; HI0, 9, requester-0 upper bound; LO1, 0, requester-1 lower bound; HI1, 9, requester-1 upper bound.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has a read pending.
REQ-005 reqN_addr  in  AW+1  start word address.
REQ-006 reqN_extra  in  EXTRA  number of words beyond the first (reads extra+1 words).
REQ-007 reqN_ready  out  1  request accepted on this edge when reqN_valid is also high.
REQ-008 respN_valid  out  1  response for requester N held.
REQ-009 respN_data  out  DW*2**EXTRA  masked read data.
REQ-010 respN_error  out  1  ROM flagged bound violation.
REQ-011 respN_ready  in  1  requester N consumes response.
REQ-012 rom_addr, rom_extra, rom_lower_bound, rom_upper_bound  out  AW+1/EXTRA/AW+1/AW+1  registered ROM request fields.
REQ-013 rom_data  in  DW*2**EXTRA; rom_error  in  1; ROM samples inputs on rising edge, outputs valid after that edge (1-cycle latency).
REQ-014 err_count  out  8  total error responses since reset.

Function
REQ-015 States: IDLE, READ, CAPT, RESP; one transaction in flight at a time.
REQ-016 reqN_ready high only in IDLE and only for the granted requester; combinational from state, valids and priority pointer.
REQ-017 Grant: single valid requester wins; both valid -> requester not granted last; pointer updates on each accept.
REQ-018 On accept edge: latch requester id, drive rom_addr/rom_extra from request, rom bounds from LON/HIN; IDLE -> READ.
REQ-019 READ -> CAPT unconditionally (ROM samples this edge); ROM request outputs held stable through READ and CAPT.
REQ-020 CAPT edge: capture rom_error and rom_data masked so bits [(extra+1)*DW-1:0] are kept and all higher bits are 0 (no X propagates); CAPT -> RESP.
REQ-021 Data packing: first word occupies the most significant kept lane, last word occupies bits [DW-1:0]; no reordering by the arbiter.
REQ-022 If rom_error=1, respN_error=1 and respN_data=0.
REQ-023 RESP: only latched requester's respN_valid high; data/error stable until respN_ready; RESP -> IDLE on respN_valid&respN_ready.
REQ-024 Latency: accept at edge k -> respN_valid high after edge k+2; next accept no earlier than edge after response handshake.
REQ-025 err_count increments at CAPT when rom_error=1; saturates at 255.
REQ-026 reqN_valid dropped before accept is ignored; no request is queued inside the arbiter.
REQ-027 extra=2**EXTRA-1 keeps the full bus; extra=0 keeps only bits [DW-1:0].

Reset
REQ-028 Reset asserted at any time, including mid-transaction: state=IDLE, priority pointer favours requester 0, respN_valid=0, respN_data=0, respN_error=0, rom_* outputs=0, err_count=0; the in-flight transaction is discarded with no response.
REQ-029 Outputs reach reset values without waiting for a clock edge.

Verification
REQ-030 req0 addr=0 extra=0, ROM word0=0x81 -> resp0_valid at edge k+2, resp0_data=0x81, upper bits 0, resp0_error=0.
REQ-031 Both valid from reset -> req0 granted first, req1 granted immediately after resp0 handshake; with both still valid, the next grant alternates.
REQ-032 req1 addr=10 with HI1=9 -> resp1_error=1, resp1_data=0, err_count 0->1.
REQ-033 addr=0 extra=3 with ROM returning X above 32 bits -> resp data exactly 0x81008200 pattern in bits [31:0], all upper bits 0.
REQ-034 resp0_ready held low 5 cycles -> resp0_valid/data stable, req1_ready stays 0, req1 granted on edge after handshake.
REQ-035 Reset pulsed during CAPT -> all outputs at reset values immediately; no response issued; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a 1-cycle-latency bounded ROM.
// Round-robin grant, one read in flight, masked and registered responses.
module rom_arbiter #(
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned EXTRA = 4,
  parameter int unsigned LO0   = 0,
  parameter int unsigned HI0   = 9,
  parameter int unsigned LO1   = 0,
  parameter int unsigned HI1   = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic [AW:0]                 req0_addr,
  input  logic [EXTRA-1:0]            req0_extra,
  output logic                        req0_ready,
  output logic                        resp0_valid,
  output logic [DW*(2**EXTRA)-1:0]    resp0_data,
  output logic                        resp0_error,
  input  logic                        resp0_ready,
  input  logic                        req1_valid,
  input  logic [AW:0]                 req1_addr,
  input  logic [EXTRA-1:0]            req1_extra,
  output logic                        req1_ready,
  output logic                        resp1_valid,
  output logic [DW*(2**EXTRA)-1:0]    resp1_data,
  output logic                        resp1_error,
  input  logic                        resp1_ready,
  output logic [AW:0]                 rom_addr,
  output logic [EXTRA-1:0]            rom_extra,
  output logic [AW:0]                 rom_lower_bound,
  output logic [AW:0]                 rom_upper_bound,
  input  logic [DW*(2**EXTRA)-1:0]    rom_data,
  input  logic                        rom_error,
  output logic [7:0]                  err_count
);
  localparam int unsigned LANES = 2**EXTRA;
  localparam int unsigned BW    = DW * LANES;
  localparam int unsigned AAW   = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state, state_nxt;
  logic          prio;   // 1: requester 1 wins a tie
  logic          owner;
  logic          grant0, grant1, accept, hs;
  logic [BW-1:0] mask, capt_data;

  assign grant0     = req0_valid & (~req1_valid | ~prio);
  assign grant1     = req1_valid & (~req0_valid | prio);
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign hs         = owner ? (resp1_valid & resp1_ready) : (resp0_valid & resp0_ready);

  // Keep lanes 0..extra; everything above is forced to zero
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i <= 32'(rom_extra)) mask[i*DW +: DW] = {DW{1'b1}};
    end
  end

  assign capt_data = rom_error ? '0 : (rom_data & mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio            <= 1'b0;
      owner           <= 1'b0;
      rom_addr        <= '0;
      rom_extra       <= '0;
      rom_lower_bound <= '0;
      rom_upper_bound <= '0;
      resp0_valid     <= 1'b0;
      resp0_data      <= '0;
      resp0_error     <= 1'b0;
      resp1_valid     <= 1'b0;
      resp1_data      <= '0;
      resp1_error     <= 1'b0;
      err_count       <= 8'd0;
    end else begin
      if (accept) begin
        owner           <= req1_ready;
        prio            <= req0_ready;
        rom_addr        <= req1_ready ? req1_addr : req0_addr;
        rom_extra       <= req1_ready ? req1_extra : req0_extra;
        rom_lower_bound <= req1_ready ? AAW'(LO1) : AAW'(LO0);
        rom_upper_bound <= req1_ready ? AAW'(HI1) : AAW'(HI0);
      end
      if (state == CAPT) begin
        if (owner) begin
          resp1_valid <= 1'b1;
          resp1_data  <= capt_data;
          resp1_error <= rom_error;
        end else begin
          resp0_valid <= 1'b1;
          resp0_data  <= capt_data;
          resp0_error <= rom_error;
        end
        if (rom_error && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
      if (hs) begin
        if (owner) resp1_valid <= 1'b0;
        else       resp0_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: directed scenarios plus randomized traffic
// against a word-level ROM model and a queue of expected responses.
module tb_rom_arbiter;
  localparam int unsigned AW = 4, DW = 8, EXTRA = 4;
  localparam int unsigned LANES = 16, BW = 128, RW = BW + 1, AAW = AW + 1;
  localparam int unsigned LO0 = 0, HI0 = 31, LO1 = 0, HI1 = 9;

  logic clk = 1'b0, reset = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW:0] req0_addr = '0, req1_addr = '0;
  logic [EXTRA-1:0] req0_extra = '0, req1_extra = '0;
  logic resp0_ready = 1'b1, resp1_ready = 1'b1;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_error, resp1_error;
  logic [BW-1:0] resp0_data, resp1_data, rom_data;
  logic rom_error;
  logic [AW:0] rom_addr, rom_lower_bound, rom_upper_bound;
  logic [EXTRA-1:0] rom_extra;
  logic [7:0] err_count;

  rom_arbiter #(.AW(AW), .DW(DW), .EXTRA(EXTRA), .LO0(LO0), .HI0(HI0), .LO1(LO1), .HI1(HI1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_extra(req0_extra), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_error(resp0_error), .resp0_ready(resp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_extra(req1_extra), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_error(resp1_error), .resp1_ready(resp1_ready),
    .rom_addr(rom_addr), .rom_extra(rom_extra), .rom_lower_bound(rom_lower_bound),
    .rom_upper_bound(rom_upper_bound), .rom_data(rom_data), .rom_error(rom_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned id; logic [RW-1:0] r; int acc_edge; } txn_t;

  logic [DW-1:0] mem [32];
  txn_t sb[$];
  int unsigned acc_id[$];
  int acc_edge_log[$], hs_log[$];
  int n_checks = 0, n_fail = 0, cyc = 0, exp_errs = 0;
  logic busy_m = 1'b0, prio_m = 1'b0, pv0 = 1'b0, pv1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ROM: lane i carries word addr+(extra-i); unused lanes and error reads return junk
  function automatic logic [RW-1:0] rom_read(int unsigned a, int unsigned e, int unsigned lo, int unsigned hi);
    logic [BW-1:0] d;
    logic err;
    err = (a < lo) || (a + e > hi);
    for (int unsigned i = 0; i < LANES; i++)
      d[i*DW +: DW] = (!err && i <= e) ? mem[5'((a + e - i) % 32)] : DW'($urandom);
    return {err, d};
  endfunction

  always @(posedge clk)
    {rom_error, rom_data} <= rom_read(32'(rom_addr), 32'(rom_extra), 32'(rom_lower_bound), 32'(rom_upper_bound));

  // Expected response: words addr..addr+extra concatenated, first word most significant
  function automatic logic [RW-1:0] model(int unsigned id, int unsigned a, int unsigned e);
    int unsigned lo, hi;
    logic [BW-1:0] d;
    lo = (id == 0) ? LO0 : LO1;
    hi = (id == 0) ? HI0 : HI1;
    if (a < lo || a + e > hi) return {1'b1, {BW{1'b0}}};
    d = '0;
    for (int unsigned i = 0; i <= e; i++) d = (d << DW) | BW'(mem[5'(a + i)]);
    return {1'b0, d};
  endfunction

  task automatic take(input int unsigned id, input logic [AW:0] a, input logic [EXTRA-1:0] e);
    txn_t t;
    t.id = id;
    t.r = model(id, 32'(a), 32'(e));
    t.acc_edge = cyc + 1;
    if (t.r[BW] && exp_errs < 255) exp_errs++;
    sb.push_back(t);
    busy_m = 1'b1;
    prio_m = (id == 0);
    acc_id.push_back(id);
    acc_edge_log.push_back(cyc + 1);
  endtask

  task automatic respond(input int unsigned id, input logic [BW-1:0] d, input logic er,
                         input logic rdy, input logic was_valid);
    txn_t t;
    n_checks++;
    if (sb.size() == 0 || sb[0].id != id) begin
      n_fail++;
      $display("FAIL resp_owner: resp%0d_valid high, pending txns %0d", id, sb.size());
    end else begin
      if (!was_valid) chk("latency", RW'(cyc), RW'(sb[0].acc_edge + 2));
      chk("resp_data", {er, d}, sb[0].r);
      chk("err_count", RW'(err_count), RW'(exp_errs));
      if (rdy) begin
        t = sb.pop_front();
        busy_m = 1'b0;
        hs_log.push_back(cyc + 1);
      end
    end
  endtask

  // Monitor: grant rule, accepts into the scoreboard, responses out of it
  always @(negedge clk) begin
    logic e0, e1;
    if (reset) begin
      sb.delete();
      busy_m = 1'b0; prio_m = 1'b0; exp_errs = 0; pv0 = 1'b0; pv1 = 1'b0;
    end else begin
      e0 = !busy_m && req0_valid && (!req1_valid || !prio_m);
      e1 = !busy_m && req1_valid && !e0;
      chk("req0_ready", RW'(req0_ready), RW'(e0));
      chk("req1_ready", RW'(req1_ready), RW'(e1));
      if (req0_valid && req0_ready) take(0, req0_addr, req0_extra);
      else if (req1_valid && req1_ready) take(1, req1_addr, req1_extra);
      if (resp0_valid) respond(0, resp0_data, resp0_error, resp0_ready, pv0);
      if (resp1_valid) respond(1, resp1_data, resp1_error, resp1_ready, pv1);
      pv0 = resp0_valid;
      pv1 = resp1_valid;
    end
  end

  task automatic check_rst();
    chk("rst_resp0", RW'({resp0_valid, resp0_error}), '0);
    chk("rst_resp1", RW'({resp1_valid, resp1_error}), '0);
    chk("rst_data0", RW'(resp0_data), '0);
    chk("rst_data1", RW'(resp1_data), '0);
    chk("rst_rom", RW'({rom_addr, rom_extra, rom_lower_bound, rom_upper_bound}), '0);
    chk("rst_err_count", RW'(err_count), '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    #1 check_rst();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic send(input int unsigned id, input int unsigned a, input int unsigned e);
    bit done = 1'b0;
    if (id == 0) begin req0_valid = 1'b1; req0_addr = AAW'(a); req0_extra = EXTRA'(e); end
    else         begin req1_valid = 1'b1; req1_addr = AAW'(a); req1_extra = EXTRA'(e); end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    chk("accept_timeout", RW'(done), RW'(1));
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_resp(input int unsigned id);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? resp0_valid : resp1_valid;
    end
    chk("resp_timeout", RW'(got), RW'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy_m; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_id.delete(); acc_edge_log.delete(); hs_log.delete();
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
    mem[0] = 8'h81; mem[1] = 8'h00; mem[2] = 8'h82; mem[3] = 8'h00;

    #1 reset = 1'b1;
    #1 check_rst();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single word read
    send(0, 0, 0);
    wait_resp(0);
    chk("single_word", RW'(resp0_data), RW'(128'h81));
    chk("single_err", RW'(resp0_error), '0);
    wait_idle();

    // Both valid from reset: 0, then 1 back-to-back, then 0 again
    do_reset();
    clear_logs();
    req0_addr = 5'd1; req0_extra = 4'd0; req1_addr = 5'd2; req1_extra = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 100 && acc_id.size() < 3; i++) @(negedge clk);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    chk("accept_count", RW'(acc_id.size()), RW'(3));
    if (acc_id.size() >= 3 && hs_log.size() >= 2) begin
      chk("grant_first", RW'(acc_id[0]), RW'(0));
      chk("grant_second", RW'(acc_id[1]), RW'(1));
      chk("grant_third", RW'(acc_id[2]), RW'(0));
      chk("b2b_grant1", RW'(acc_edge_log[1]), RW'(hs_log[0] + 1));
      chk("b2b_grant2", RW'(acc_edge_log[2]), RW'(hs_log[1] + 1));
    end
    wait_idle();

    // Out-of-bounds read on requester 1
    send(1, 10, 0);
    wait_resp(1);
    chk("bound_err", RW'(resp1_error), RW'(1));
    chk("bound_data", RW'(resp1_data), '0);
    chk("err_count_one", RW'(err_count), RW'(1));
    wait_idle();

    // Four-word read, junk above 32 bits must be masked
    send(0, 0, 3);
    wait_resp(0);
    chk("pattern4", RW'(resp0_data), RW'(128'h81008200));
    wait_idle();

    // Full-bus read
    send(0, 0, 15);
    wait_resp(0);
    chk("full_top_lane", RW'(resp0_data[BW-1 -: DW]), RW'(mem[0]));
    chk("full_low_lane", RW'(resp0_data[DW-1:0]), RW'(mem[15]));
    wait_idle();

    // Back-pressure on resp0 with req1 waiting
    do_reset();
    clear_logs();
    resp0_ready = 1'b0;
    req1_addr = 5'd4; req1_extra = 4'd0; req1_valid = 1'b1;
    send(0, 6, 1);
    wait_resp(0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", RW'(resp0_valid), RW'(1));
      chk("hold_req1_ready", RW'(req1_ready), '0);
    end
    @(posedge clk); #1 resp0_ready = 1'b1;
    for (int i = 0; i < 20 && acc_id.size() < 2; i++) @(negedge clk);
    chk("bp_accept_count", RW'(acc_id.size()), RW'(2));
    if (acc_id.size() >= 2 && hs_log.size() >= 1) begin
      chk("bp_grant_id", RW'(acc_id[1]), RW'(1));
      chk("bp_grant_edge", RW'(acc_edge_log[1]), RW'(hs_log[0] + 1));
    end
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_idle();

    // Reset in CAPT drops the transaction
    send(1, 10, 0);
    wait_idle();
    send(0, 5, 2);
    @(posedge clk); #1 reset = 1'b1;
    #1 check_rst();
    @(posedge clk); #1 reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_resp_after_rst", RW'({resp0_valid, resp1_valid}), '0);
    end
    send(0, 2, 1);
    wait_resp(0);
    wait_idle();

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_addr  = AAW'($urandom);
      req0_extra = ($urandom_range(0, 3) == 0) ? EXTRA'($urandom) : EXTRA'($urandom_range(0, 3));
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_addr  = AAW'($urandom_range(0, 12));
      req1_extra = EXTRA'($urandom_range(0, 3));
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
    wait_idle();

    // Error counter saturation
    for (int i = 0; i < 260; i++) send(1, 10, 0);
    wait_idle();
    chk("err_sat", RW'(err_count), RW'(255));

    chk("drain", RW'(busy_m || sb.size() != 0), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
